// File: rtl/code_table_pkg.sv
// Shared types and defaults for the code table loader: command opcodes,
// loader FSM states, default phase timing and table geometry.
package code_table_pkg;

   localparam int DEF_SETUP_CYCLES = 2;
   localparam int DEF_PULSE_CYCLES = 4;
   localparam int DEF_DEPTH_LOG2   = 8;
   localparam int TABLE_DEPTH      = 2 ** DEF_DEPTH_LOG2;
   localparam int CNT_W            = 8;

   typedef enum logic [1:0] {
      OP_WRITE     = 2'd0,
      OP_REWIND    = 2'd1,
      OP_WRITE_INC = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IDX_SETUP,
      ST_IDX_PULSE,
      ST_IDX_HOLD,
      ST_CODE_PULSE,
      ST_CODE_HOLD,
      ST_DONE
   } state_e;

endpackage

// File: rtl/code_table_loader_if.sv
// Command stream plus code-table strobe bus of the loader. The slave modport
// is the loader; the master modport is everything around it (host and table).
interface code_table_loader_if #(
   parameter int DEPTH_LOG2 = 8
);
   logic                  iCmd_valid;
   logic                  oCmd_ready;
   logic [1:0]            iCmd_op;
   logic [DEPTH_LOG2-1:0] iCmd_addr;
   logic [31:0]           iCmd_data;
   logic [31:0]           iCode;
   logic                  oSET_INDEX_FLAG;
   logic [DEPTH_LOG2-1:0] oSET_INDEX;
   logic                  oSET_CODE_FLAG;
   logic [31:0]           oSET_CODE;
   logic                  oBusy;
   logic                  oDone;
   logic                  oErr;

   modport slave (
      input  iCmd_valid, iCmd_op, iCmd_addr, iCmd_data, iCode,
      output oCmd_ready, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
             oBusy, oDone, oErr
   );

   modport master (
      output iCmd_valid, iCmd_op, iCmd_addr, iCmd_data, iCode,
      input  oCmd_ready, oSET_INDEX_FLAG, oSET_INDEX, oSET_CODE_FLAG, oSET_CODE,
             oBusy, oDone, oErr
   );
endinterface

// File: rtl/strobe_timer.sv
// Loadable down-counter shared by every loader phase; tc_o is high while the
// count sits at zero, i.e. during the last cycle of the current phase.
module strobe_timer
   import code_table_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: reset is synchronous (sampled on the clock edge) and all state uses <=.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/code_table_loader.sv
// Turns write/rewind commands into timed, register-driven set-index and
// set-code strobes for the external code table. Readback check: CODE_TABLE_LOADER_VERIFY_EN.
module code_table_loader
   import code_table_pkg::*;
#(
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2
) (
   input logic                iClk,
   input logic                iRst,
   code_table_loader_if.slave bus
);

   // IDX_SETUP also spans the accept cycle, so it loads S rather than S-1.
   localparam logic [CNT_W-1:0] SETUP_FIRST = CNT_W'(SETUP_CYCLES);
   localparam logic [CNT_W-1:0] SETUP_LEN   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LEN   = CNT_W'(PULSE_CYCLES - 1);

   state_e                state_q;
   logic                  ready_q;
   logic                  done_q;
   logic                  idx_flag_q;
   logic                  code_flag_q;
   logic                  is_rewind_q;
   logic [DEPTH_LOG2-1:0] index_q;
   logic [DEPTH_LOG2-1:0] ptr_q;
   logic [31:0]           code_q;
   logic                  tc;
   logic                  tmr_load;
   logic [CNT_W-1:0]      tmr_val;
   logic                  accept;
   op_e                   op;

   assign accept = bus.iCmd_valid && ready_q;
   assign op     = op_e'(bus.iCmd_op);

   strobe_timer u_timer (
      .clk       (iClk),
      .rst_n     (iRst),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .tc_o      (tc)
   );

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: if (accept && op != OP_RSVD) begin
            tmr_load = 1'b1;
            tmr_val  = SETUP_FIRST;
         end
         ST_IDX_SETUP:  if (tc) begin tmr_load = 1'b1; tmr_val = PULSE_LEN; end
         ST_IDX_PULSE:  if (tc) begin tmr_load = 1'b1; tmr_val = SETUP_LEN; end
         ST_IDX_HOLD:   if (tc && !is_rewind_q) begin tmr_load = 1'b1; tmr_val = PULSE_LEN; end
         ST_CODE_PULSE: if (tc) begin tmr_load = 1'b1; tmr_val = SETUP_LEN; end
         default: ;
      endcase
   end

`ifdef CODE_TABLE_LOADER_VERIFY_EN
   logic err_q;
   assign bus.oErr = err_q;
`else
   assign bus.oErr = 1'b0;
`endif

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         idx_flag_q  <= 1'b0;
         code_flag_q <= 1'b0;
         is_rewind_q <= 1'b0;
         index_q     <= '0;
         ptr_q       <= '0;
         code_q      <= '0;
`ifdef CODE_TABLE_LOADER_VERIFY_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               ready_q     <= 1'b0;
               is_rewind_q <= (op == OP_REWIND);
               state_q     <= ST_IDX_SETUP;
               case (op)
                  OP_WRITE: begin
                     index_q <= bus.iCmd_addr;
                     code_q  <= bus.iCmd_data;
                     ptr_q   <= bus.iCmd_addr + 1'b1;
                  end
                  OP_WRITE_INC: begin
                     index_q <= ptr_q;
                     code_q  <= bus.iCmd_data;
                     ptr_q   <= ptr_q + 1'b1;
                  end
                  OP_REWIND: begin
                     index_q <= bus.iCmd_addr;
                     ptr_q   <= bus.iCmd_addr;
`ifdef CODE_TABLE_LOADER_VERIFY_EN
                     if (&bus.iCmd_addr) err_q <= 1'b0;
`endif
                  end
                  default: begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               endcase
            end
            ST_IDX_SETUP: if (tc) begin
               state_q    <= ST_IDX_PULSE;
               idx_flag_q <= 1'b1;
            end
            ST_IDX_PULSE: if (tc) begin
               state_q    <= ST_IDX_HOLD;
               idx_flag_q <= 1'b0;
            end
            ST_IDX_HOLD: if (tc) begin
               if (is_rewind_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q     <= ST_CODE_PULSE;
                  code_flag_q <= 1'b1;
               end
            end
            ST_CODE_PULSE: if (tc) begin
               state_q     <= ST_CODE_HOLD;
               code_flag_q <= 1'b0;
            end
            ST_CODE_HOLD: if (tc) begin
               state_q <= ST_DONE;
               done_q  <= 1'b1;
`ifdef CODE_TABLE_LOADER_VERIFY_EN
               if (bus.iCode != code_q) err_q <= 1'b1;
`endif
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.oCmd_ready      = ready_q;
   assign bus.oBusy           = ~ready_q;
   assign bus.oDone           = done_q;
   assign bus.oSET_INDEX_FLAG = idx_flag_q;
   assign bus.oSET_CODE_FLAG  = code_flag_q;
   assign bus.oSET_INDEX      = index_q;
   assign bus.oSET_CODE       = code_q;

endmodule

// File: tb/tb_code_table_loader.sv
// Directed bench for code_table_loader with a behavioural model of the
// edge-sensitive code table (index on falling set-index, write on falling set-code).
module tb_code_table_loader;
   import code_table_pkg::*;

   localparam int S  = 2;
   localparam int P  = 4;
   localparam int DW = 8;

   logic iClk = 1'b0;
   logic iRst = 1'b0;
   always #5 iClk = ~iClk;

   code_table_loader_if #(.DEPTH_LOG2(DW)) bus ();

   code_table_loader #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .DEPTH_LOG2(DW)) dut (
      .iClk(iClk),
      .iRst(iRst),
      .bus (bus)
   );

   // Table model
   logic [31:0]   mem [TABLE_DEPTH];
   logic [DW-1:0] tbl_idx;
   logic          force_zero;

   always @(negedge bus.oSET_INDEX_FLAG) tbl_idx = bus.oSET_INDEX;
   always @(negedge bus.oSET_CODE_FLAG) mem[tbl_idx] = bus.oSET_CODE;
   assign bus.iCode = force_zero ? 32'h0 : mem[tbl_idx];

   int checks = 0;
   int errors = 0;

   // Trace of the most recent command, cycle 0 = just after the accept edge
   logic [63:0]   idx_mask, code_mask;
   int            done_cyc;
   bit            ready_bad, overlap, unstable;
   logic [DW-1:0] idx_val;
   logic [31:0]   code_val;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [DW-1:0] addr, input logic [31:0] data);
      int guard = 0;
      while (!bus.oCmd_ready && guard < 50) begin tick(); guard++; end
      bus.iCmd_valid = 1'b1;
      bus.iCmd_op    = op;
      bus.iCmd_addr  = addr;
      bus.iCmd_data  = data;
      tick();
      bus.iCmd_valid = 1'b0;
      idx_mask  = '0;
      code_mask = '0;
      done_cyc  = -1;
      ready_bad = 1'b0;
      overlap   = 1'b0;
      unstable  = 1'b0;
      idx_val   = bus.oSET_INDEX;
      code_val  = bus.oSET_CODE;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) tick();
         idx_mask[k]  = bus.oSET_INDEX_FLAG;
         code_mask[k] = bus.oSET_CODE_FLAG;
         if (bus.oSET_INDEX_FLAG && bus.oSET_CODE_FLAG) overlap = 1'b1;
         if (bus.oCmd_ready) ready_bad = 1'b1;
         if (bus.oSET_INDEX !== idx_val || bus.oSET_CODE !== code_val) unstable = 1'b1;
         if (bus.oDone) begin done_cyc = k; break; end
      end
      tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (bus.oSET_INDEX_FLAG !== 1'b0 || bus.oSET_CODE_FLAG !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b want 00", bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG); end
      checks++; if (bus.oSET_INDEX !== 8'd0 || bus.oSET_CODE !== 32'd0) begin errors++; $display("FAIL reset_busses got %h/%h want 0/0", bus.oSET_INDEX, bus.oSET_CODE); end
      checks++; if (bus.oDone !== 1'b0 || bus.oErr !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", bus.oDone, bus.oErr); end
      iRst = 1'b1;
      tick();
      checks++; if (bus.oCmd_ready !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_ready got rdy=%b busy=%b want 1/0", bus.oCmd_ready, bus.oBusy); end
   endtask

   task automatic test_write();
      send(OP_WRITE, 8'd5, 32'hDEAD_BEEF);
      checks++; if (idx_mask !== 64'h78) begin errors++; $display("FAIL write_idx_strobe got %h want %h", idx_mask, 64'h78); end
      checks++; if (code_mask !== 64'h1E00) begin errors++; $display("FAIL write_code_strobe got %h want %h", code_mask, 64'h1E00); end
      checks++; if (done_cyc != 15) begin errors++; $display("FAIL write_latency got %0d want 15", done_cyc); end
      checks++; if (ready_bad || overlap || unstable) begin errors++; $display("FAIL write_rules got rdy=%b ovl=%b unst=%b want 000", ready_bad, overlap, unstable); end
      checks++; if (idx_val !== 8'd5 || code_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_bus got %h/%h want 05/deadbeef", idx_val, code_val); end
      checks++; if (mem[5] !== 32'hDEAD_BEEF || tbl_idx !== 8'd5) begin errors++; $display("FAIL write_table got %h@%h want deadbeef@05", mem[5], tbl_idx); end
      checks++; if (bus.oCmd_ready !== 1'b1 || bus.oBusy !== 1'b0) begin errors++; $display("FAIL write_idle got rdy=%b busy=%b want 1/0", bus.oCmd_ready, bus.oBusy); end
   endtask

   task automatic test_write_inc();
      send(OP_WRITE, 8'd254, 32'hAAAA_0000);
      send(OP_WRITE_INC, 8'd9, 32'd1);
      checks++; if (idx_val !== 8'd255) begin errors++; $display("FAIL inc1_index got %0d want 255", idx_val); end
      send(OP_WRITE_INC, 8'd9, 32'd2);
      checks++; if (idx_val !== 8'd0) begin errors++; $display("FAIL inc2_index got %0d want 0", idx_val); end
      send(OP_WRITE_INC, 8'd9, 32'd3);
      checks++; if (idx_val !== 8'd1 || done_cyc != 15) begin errors++; $display("FAIL inc3_index got %0d lat %0d want 1 lat 15", idx_val, done_cyc); end
      checks++; if (mem[254] !== 32'hAAAA_0000 || mem[255] !== 32'd1 || mem[0] !== 32'd2 || mem[1] !== 32'd3)
         begin errors++; $display("FAIL inc_table got %h %h %h %h want aaaa0000 1 2 3", mem[254], mem[255], mem[0], mem[1]); end
   endtask

   task automatic test_rewind();
      send(OP_REWIND, 8'd0, 32'hFFFF_FFFF);
      checks++; if (idx_mask !== 64'h78 || code_mask !== 64'h0) begin errors++; $display("FAIL rewind_strobes got %h/%h want 78/0", idx_mask, code_mask); end
      checks++; if (done_cyc != 9) begin errors++; $display("FAIL rewind_latency got %0d want 9", done_cyc); end
      checks++; if (tbl_idx !== 8'd0 || mem[1] !== 32'd3) begin errors++; $display("FAIL rewind_table got idx %0d mem1 %h want 0/3", tbl_idx, mem[1]); end
      send(OP_WRITE_INC, 8'd77, 32'h0000_0044);
      checks++; if (idx_val !== 8'd0 || mem[0] !== 32'h44) begin errors++; $display("FAIL rewind_ptr got %0d/%h want 0/44", idx_val, mem[0]); end
   endtask

   task automatic test_reserved();
      send(OP_RSVD, 8'd7, 32'h55);
      checks++; if (idx_mask !== 64'h0 || code_mask !== 64'h0) begin errors++; $display("FAIL rsvd_strobes got %h/%h want 0/0", idx_mask, code_mask); end
      checks++; if (done_cyc < 0 || done_cyc > 1) begin errors++; $display("FAIL rsvd_done got %0d want 0..1", done_cyc); end
      checks++; if (mem[7] !== 32'd0 || bus.oCmd_ready !== 1'b1) begin errors++; $display("FAIL rsvd_side got mem7 %h rdy %b want 0/1", mem[7], bus.oCmd_ready); end
   endtask

   task automatic test_back_to_back();
      int first_ready = -1, d1 = -1, d2 = -1;
      bit ovl = 1'b0, rdy2_bad = 1'b0;
      logic [DW-1:0] idx2 = '0;
      bus.iCmd_valid = 1'b1;
      bus.iCmd_op    = OP_WRITE;
      bus.iCmd_addr  = 8'd10;
      bus.iCmd_data  = 32'h1111_0000;
      tick();
      bus.iCmd_addr  = 8'd11;
      bus.iCmd_data  = 32'h2222_0000;
      for (int k = 0; k < 60; k++) begin
         if (k > 0) tick();
         if (bus.oSET_INDEX_FLAG && bus.oSET_CODE_FLAG) ovl = 1'b1;
         if (bus.oCmd_ready && first_ready < 0 && k > 0) first_ready = k;
         if (first_ready >= 0 && k == first_ready + 1) begin bus.iCmd_valid = 1'b0; idx2 = bus.oSET_INDEX; end
         if (first_ready >= 0 && k > first_ready && d2 < 0 && bus.oCmd_ready) rdy2_bad = 1'b1;
         if (bus.oDone) begin
            if (d1 < 0) d1 = k;
            else if (k > d1) begin d2 = k; break; end
         end
      end
      bus.iCmd_valid = 1'b0;
      tick();
      checks++; if (d1 != 15 || first_ready != 16) begin errors++; $display("FAIL b2b_first got done %0d ready %0d want 15/16", d1, first_ready); end
      checks++; if (d2 != 32 || idx2 !== 8'd11) begin errors++; $display("FAIL b2b_second got done %0d idx %0d want 32/11", d2, idx2); end
      checks++; if (ovl || rdy2_bad) begin errors++; $display("FAIL b2b_rules got ovl=%b rdy=%b want 0/0", ovl, rdy2_bad); end
      checks++; if (mem[10] !== 32'h1111_0000 || mem[11] !== 32'h2222_0000) begin errors++; $display("FAIL b2b_table got %h %h want 11110000 22220000", mem[10], mem[11]); end
   endtask

   task automatic test_reset_mid();
      bit saw_done = 1'b0;
      bus.iCmd_valid = 1'b1;
      bus.iCmd_op    = OP_WRITE;
      bus.iCmd_addr  = 8'd30;
      bus.iCmd_data  = 32'hCAFE_0000;
      tick();
      bus.iCmd_valid = 1'b0;
      repeat (10) tick();
      checks++; if (bus.oSET_CODE_FLAG !== 1'b1) begin errors++; $display("FAIL rstmid_pulse got %b want 1", bus.oSET_CODE_FLAG); end
      iRst = 1'b0;
      tick();
      checks++; if (bus.oSET_CODE_FLAG !== 1'b0 || bus.oSET_INDEX_FLAG !== 1'b0 || bus.oDone !== 1'b0)
         begin errors++; $display("FAIL rstmid_drop got %b%b%b want 000", bus.oSET_INDEX_FLAG, bus.oSET_CODE_FLAG, bus.oDone); end
      iRst = 1'b1;
      for (int k = 0; k < 25; k++) begin tick(); if (bus.oDone) saw_done = 1'b1; end
      checks++; if (saw_done || bus.oCmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got done=%b rdy=%b want 0/1", saw_done, bus.oCmd_ready); end
      send(OP_WRITE_INC, 8'd99, 32'h0000_0088);
      checks++; if (idx_val !== 8'd0) begin errors++; $display("FAIL rstmid_ptr got %0d want 0", idx_val); end
   endtask

   task automatic test_verify();
      force_zero = 1'b1;
      send(OP_WRITE, 8'd20, 32'h1234_5678);
      force_zero = 1'b0;
      checks++; if (done_cyc != 15) begin errors++; $display("FAIL verify_latency got %0d want 15", done_cyc); end
`ifdef CODE_TABLE_LOADER_VERIFY_EN
      checks++; if (bus.oErr !== 1'b1) begin errors++; $display("FAIL verify_set got %b want 1", bus.oErr); end
      send(OP_WRITE, 8'd21, 32'hABCD_0001);
      checks++; if (bus.oErr !== 1'b1 || mem[21] !== 32'hABCD_0001) begin errors++; $display("FAIL verify_sticky got %b/%h want 1/abcd0001", bus.oErr, mem[21]); end
      send(OP_REWIND, 8'd255, 32'h0);
      checks++; if (bus.oErr !== 1'b0 || done_cyc != 9) begin errors++; $display("FAIL verify_clear got %b lat %0d want 0/9", bus.oErr, done_cyc); end
`else
      checks++; if (bus.oErr !== 1'b0) begin errors++; $display("FAIL verify_off got %b want 0", bus.oErr); end
`endif
   endtask

   initial begin
      for (int i = 0; i < TABLE_DEPTH; i++) mem[i] = 32'h0;
      tbl_idx        = '0;
      force_zero     = 1'b0;
      bus.iCmd_valid = 1'b0;
      bus.iCmd_op    = 2'd0;
      bus.iCmd_addr  = '0;
      bus.iCmd_data  = '0;
      test_reset();
      test_write();
      test_write_inc();
      test_rewind();
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      test_verify();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
